// File: rtl/store_buffer.sv
// store_buffer: write-behind store FIFO between MEM and Data_mem; loads get the RAM port first.
// Define SB_FORWARD_EN for store-to-load forwarding; otherwise a matching load stalls until drained.
module store_buffer #(
    parameter int DSIZE = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                       Clk_In,
    input  logic                       Rst,
    input  logic                       Req_Valid,
    input  logic                       Req_Write,
    input  logic [DSIZE-1:0]           Req_Addr,
    input  logic [DSIZE-1:0]           Req_Data,
    output logic                       Req_Stall,
    input  logic                       Port_Busy,
    output logic                       Ld_Valid,
    output logic [DSIZE-1:0]           Ld_Data,
    output logic                       Ram_Enable,
    output logic                       Ram_Write_Enab,
    output logic [DSIZE-1:0]           Ram_Add,
    output logic [DSIZE-1:0]           Ram_Data,
    input  logic [DSIZE-1:0]           Ram_Rdata,
    output logic [$clog2(DEPTH):0]     Sb_Count,
    output logic                       Sb_Empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DSIZE-1:0] addr_q [DEPTH];
    logic [DSIZE-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic             hit, ld_ok, pop, push, ld_valid_q;
`ifdef SB_FORWARD_EN
    logic [DSIZE-1:0] hit_data;
`endif

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit = 1'b0;
`ifdef SB_FORWARD_EN
        hit_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_q[head + PW'(k)] && addr_q[head + PW'(k)][AW-1:0] == Req_Addr[AW-1:0]) begin
                hit = 1'b1;
`ifdef SB_FORWARD_EN
                hit_data = data_q[head + PW'(k)];
`endif
            end
        end
    end

`ifdef SB_FORWARD_EN
    assign ld_ok = Req_Valid & ~Req_Write & ~Port_Busy & ~Rst;
`else
    assign ld_ok = Req_Valid & ~Req_Write & ~Port_Busy & ~hit & ~Rst;
`endif
    assign pop            = (count != '0) & ~Port_Busy & ~ld_ok;
    assign push           = Req_Valid & Req_Write & ((count < CW'(DEPTH)) | pop);
    assign Req_Stall      = Req_Valid & (Req_Write ? ~push : ~ld_ok);
    assign Ram_Enable     = ld_ok | pop;
    assign Ram_Write_Enab = pop;
    assign Ram_Add        = ld_ok ? Req_Addr : (pop ? addr_q[head] : '0);
    assign Ram_Data       = pop ? data_q[head] : '0;
    assign Sb_Count       = count;
    assign Sb_Empty       = (count == '0);
    assign Ld_Valid       = ld_valid_q;

    always_ff @(posedge Clk_In or posedge Rst) begin
        if (Rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            vld_q      <= '0;
            ld_valid_q <= 1'b0;
        end else begin
            if (pop) begin
                vld_q[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            // On a full push+pop tail equals head; the push must win the valid bit.
            if (push) begin
                vld_q[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            count      <= count + CW'(push) - CW'(pop);
            ld_valid_q <= ld_ok;
        end
    end

    always_ff @(posedge Clk_In) begin
        if (push) begin
            addr_q[tail] <= Req_Addr;
            data_q[tail] <= Req_Data;
        end
    end

`ifdef SB_FORWARD_EN
    logic             fwd_q;
    logic [DSIZE-1:0] fwd_data_q;

    always_ff @(posedge Clk_In or posedge Rst) begin
        if (Rst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= ld_ok & hit;
            fwd_data_q <= hit_data;
        end
    end

    assign Ld_Data = ld_valid_q ? (fwd_q ? fwd_data_q : Ram_Rdata) : '0;
`else
    assign Ld_Data = ld_valid_q ? Ram_Rdata : '0;
`endif
endmodule
